// File: rtl/led_frame_sequencer.sv
// Expands a periodic snapshot of per-bin colours and LED counts into a LEDS-pixel stream,
// bins in order, padded with black or truncated; pixels leave on a registered valid/ready port.
module led_frame_sequencer #(
   parameter int LEDS           = 50,
   parameter int BIN_QTY        = 12,
   parameter int REFRESH_CYCLES = 1000000,
   localparam int CW            = $clog2(LEDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BIN_QTY-1:0][23:0]     rgb_i,
   input  logic [BIN_QTY-1:0][CW-1:0]   ledCounts_i,
   input  logic                         data_v_i,
   output logic [23:0]                  pix_o,
   output logic                         pix_v_o,
   input  logic                         pix_ready_i,
   output logic                         last_o,
   output logic                         busy_o,
   output logic [15:0]                  frame_cnt_o
);

   localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
   localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, EMIT, PAD} state_t;

   state_t                      state_q, state_d;
   logic [TW-1:0]               tmr_q, tmr_d;
   logic                        req_q, req_d;
   logic [BIN_QTY-1:0][23:0]    snap_rgb_q, snap_rgb_d;
   logic [BIN_QTY-1:0][CW-1:0]  snap_cnt_q, snap_cnt_d;
   logic [CW-1:0]               p_q, p_d;
   logic [BW-1:0]               b_q, b_d;
   logic [CW-1:0]               r_q, r_d;
   logic [23:0]                 pix_q, pix_d;
   logic                        pix_v_q, pix_v_d;
   logic                        last_q, last_d;
   logic [15:0]                 frame_cnt_q, frame_cnt_d;

   logic          tmr_expire;
   logic          hs;
   logic          slot_free;
   logic          frame_end;
   logic [CW-1:0] p_nxt;
   logic [BW-1:0] b_inc;

   assign tmr_expire = (tmr_q == TW'(REFRESH_CYCLES - 1));
   assign hs         = pix_v_q && pix_ready_i;
   assign slot_free  = !pix_v_q || hs;
   assign frame_end  = hs && (p_q == CW'(LEDS - 1));
   // p_q is the index of the pixel on the port; the next one loaded takes p_nxt.
   assign p_nxt      = hs ? p_q + 1'b1 : p_q;
   assign b_inc      = b_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_expire ? '0 : tmr_q + 1'b1;
      req_d       = req_q;
      snap_rgb_d  = snap_rgb_q;
      snap_cnt_d  = snap_cnt_q;
      p_d         = p_q;
      b_d         = b_q;
      r_d         = r_q;
      pix_d       = pix_q;
      pix_v_d     = pix_v_q;
      last_d      = last_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         IDLE: begin
            if (req_q && data_v_i) begin
               snap_rgb_d = rgb_i;
               snap_cnt_d = ledCounts_i;
               req_d      = 1'b0;
               p_d        = '0;
               b_d        = '0;
               r_d        = ledCounts_i[0];
               state_d    = EMIT;
            end
         end
         EMIT, PAD: begin
            if (frame_end) begin
               state_d     = IDLE;
               pix_d       = '0;
               pix_v_d     = 1'b0;
               last_d      = 1'b0;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else if (slot_free) begin
               p_d     = p_nxt;
               pix_v_d = 1'b0;
               last_d  = 1'b0;
               if (state_q == PAD) begin
                  pix_d   = '0;
                  pix_v_d = 1'b1;
                  last_d  = (p_nxt == CW'(LEDS - 1));
               end else if (r_q == '0) begin
                  // Bin exhausted: a bubble cycle while the next count is fetched.
                  if (b_q != BW'(BIN_QTY - 1)) begin
                     b_d = b_inc;
                     r_d = snap_cnt_q[b_inc];
                  end else begin
                     state_d = PAD;
                  end
               end else begin
                  pix_d   = snap_rgb_q[b_q];
                  pix_v_d = 1'b1;
                  last_d  = (p_nxt == CW'(LEDS - 1));
                  r_d     = r_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // An expiry on the snapshot edge is a new request, so it overrides the clear.
      if (tmr_expire) begin
         req_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         req_q       <= 1'b0;
         snap_rgb_q  <= '0;
         snap_cnt_q  <= '0;
         p_q         <= '0;
         b_q         <= '0;
         r_q         <= '0;
         pix_q       <= '0;
         pix_v_q     <= 1'b0;
         last_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         req_q       <= req_d;
         snap_rgb_q  <= snap_rgb_d;
         snap_cnt_q  <= snap_cnt_d;
         p_q         <= p_d;
         b_q         <= b_d;
         r_q         <= r_d;
         pix_q       <= pix_d;
         pix_v_q     <= pix_v_d;
         last_q      <= last_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_o       = pix_q;
   assign pix_v_o     = pix_v_q;
   assign last_o      = last_q;
   assign busy_o      = (state_q != IDLE);
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: table of frame setups, a reference expansion pushed to a
// scoreboard queue per frame, popped on every accepted pixel; plus gating, period and reset sequences.
module tb_led_frame_sequencer;

   localparam int LEDS = 50;
   localparam int BINS = 12;
   localparam int CW   = 6;
   localparam int REF  = 100;
   localparam int NVEC = 7;

   typedef logic [BINS-1:0][23:0]   rgbv_t;
   typedef logic [BINS-1:0][CW-1:0] cntv_t;

   typedef struct {
      rgbv_t rgb;
      cntv_t cnt;
      int    mode;      // 0: ready held high, 1: random ready with a stall at pixel 25
      int    exp_cnt;   // frame_cnt_o expected after this frame
      bit    per_chk;   // frame must start exactly REF cycles after the previous one
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   rgbv_t       rgb;
   cntv_t       cnt;
   logic        data_v;
   logic [23:0] pix_o;
   logic        pix_v_o;
   logic        rdy;
   logic        last_o;
   logic        busy_o;
   logic [15:0] frame_cnt_o;

   vec_t        tbl [NVEC];
   logic [24:0] exp_q [$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          mode = 0;
   int          hs_cnt = 0;
   int          stall_left = 0;
   int          cyc = 0;

   led_frame_sequencer #(.LEDS(LEDS), .BIN_QTY(BINS), .REFRESH_CYCLES(REF)) dut (
      .clk         (clk),
      .rst         (rst),
      .rgb_i       (rgb),
      .ledCounts_i (cnt),
      .data_v_i    (data_v),
      .pix_o       (pix_o),
      .pix_v_o     (pix_v_o),
      .pix_ready_i (rdy),
      .last_o      (last_o),
      .busy_o      (busy_o),
      .frame_cnt_o (frame_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference expansion: bins in order, each colour repeated count times, cut or padded to LEDS.
   task automatic push_frame(input rgbv_t rv, input cntv_t cv);
      int n = 0;
      for (int b = 0; b < BINS; b++)
         for (int k = 0; k < int'(cv[b]); k++)
            if (n < LEDS) begin
               exp_q.push_back({(n == LEDS - 1), rv[b]});
               n++;
            end
      while (n < LEDS) begin
         exp_q.push_back({(n == LEDS - 1), 24'h000000});
         n++;
      end
   endtask

   task automatic wait_busy(input logic lvl, input int lim, input string nm);
      int k;
      for (k = 0; k < lim; k++) begin
         @(negedge clk);
         if (busy_o === lvl) break;
      end
      n_chk++;
      if (k == lim) begin
         n_fail++;
         $display("FAIL %s: busy_o stayed %0b for %0d cycles, expected %0b", nm, !lvl, lim, lvl);
      end
   endtask

   // Ready driver, changes just after the active edge.
   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mode == 0) begin
            rdy = 1'b1;
         end else if (!busy_o) begin
            stall_left = 5;
            rdy = 1'b1;
         end else if (hs_cnt == 25 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Output monitor: hold-stability under stall, last_o qualification, scoreboard pop.
   initial begin
      logic        prev_v, prev_rdy, prev_last;
      logic [23:0] prev_pix;
      logic [24:0] e;
      prev_v = 1'b0; prev_rdy = 1'b0; prev_last = 1'b0; prev_pix = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            hs_cnt = 0;
         end else begin
            if (!busy_o) hs_cnt = 0;
            if (prev_v && !prev_rdy) begin
               n_chk++;
               if (pix_v_o !== 1'b1 || pix_o !== prev_pix || last_o !== prev_last) begin
                  n_fail++;
                  $display("FAIL hold: got v=%0b pix=%06h last=%0b, expected v=1 pix=%06h last=%0b",
                           pix_v_o, pix_o, last_o, prev_pix, prev_last);
               end
            end
            if (last_o) begin
               n_chk++;
               if (pix_v_o !== 1'b1) begin
                  n_fail++;
                  $display("FAIL last_qual: last_o=1 with pix_v_o=%0b, expected 1", pix_v_o);
               end
            end
            if (pix_v_o && rdy) begin
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL extra_pixel: got pix=%06h last=%0b, expected no pixel", pix_o, last_o);
               end else begin
                  e = exp_q.pop_front();
                  if ({last_o, pix_o} !== e) begin
                     n_fail++;
                     $display("FAIL pixel %0d: got pix=%06h last=%0b, expected pix=%06h last=%0b",
                              hs_cnt, pix_o, last_o, e[23:0], e[24]);
                  end
               end
               hs_cnt++;
            end
            prev_v = pix_v_o; prev_rdy = rdy; prev_pix = pix_o; prev_last = last_o;
         end
      end
   end

   initial begin
      int rise, start, end_c, prev_start, prev_end, idle_viol;
      rgbv_t basic_rgb;
      cntv_t basic_cnt;

      for (int i = 0; i < NVEC; i++) begin
         tbl[i].rgb = '0; tbl[i].cnt = '0; tbl[i].mode = 0;
         tbl[i].exp_cnt = i + 1; tbl[i].per_chk = (i >= 2 && i <= 5);
      end
      tbl[0].rgb[0] = 24'hFF0000; tbl[0].rgb[1] = 24'h00FF00;
      tbl[0].cnt[0] = 6'd20;      tbl[0].cnt[1] = 6'd30;
      tbl[1].rgb[5] = 24'h123456; tbl[1].cnt[5] = 6'd10; tbl[1].rgb[2] = 24'hABCDEF;
      tbl[2].rgb[0] = 24'h0000FF; tbl[2].rgb[1] = 24'hFFFFFF;
      tbl[2].cnt[0] = 6'd40;      tbl[2].cnt[1] = 6'd40;
      for (int b = 0; b < BINS; b++) begin
         tbl[3].rgb[b] = 24'h111111 * (b + 1);
         tbl[3].cnt[b] = 6'd1;
      end
      tbl[4].rgb[11] = 24'hC0FFEE; tbl[4].cnt[11] = 6'd50; tbl[4].rgb[0] = 24'h777777;
      tbl[5].rgb = tbl[0].rgb; tbl[5].cnt = tbl[0].cnt; tbl[5].mode = 1;
      tbl[6].rgb = tbl[0].rgb; tbl[6].cnt = tbl[0].cnt;
      basic_rgb = tbl[0].rgb; basic_cnt = tbl[0].cnt;

      rst = 1'b1; data_v = 1'b0; rgb = tbl[0].rgb; cnt = tbl[0].cnt;
      prev_start = 0; prev_end = 0;
      repeat (3) @(negedge clk);
      chk("rst_pix", pix_o, 0);
      chk("rst_pix_v", pix_v_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_frame_cnt", frame_cnt_o, 0);
      rst = 1'b0;

      // Requests pile up while upstream data is not valid; none may start a frame.
      idle_viol = 0;
      repeat (330) begin
         @(negedge clk);
         if (busy_o || pix_v_o) idle_viol++;
      end
      chk("gate_idle", idle_viol, 0);
      push_frame(tbl[0].rgb, tbl[0].cnt);
      data_v = 1'b1;
      rise = cyc;

      for (int i = 0; i < NVEC; i++) begin
         mode = tbl[i].mode;
         wait_busy(1'b1, 300, "frame_start");
         start = cyc;
         chk("first_v_not_early", pix_v_o, 0);
         if (i == 0) chk("gate_latency", start - rise, 1);
         if (i == 1) chk("collapsed_req_gap", (start - prev_end) > 1, 1);
         if (tbl[i].per_chk) chk("refresh_period", start - prev_start, REF);
         repeat (5) @(negedge clk);
         for (int b = 0; b < BINS; b++) begin
            rgb[b] = 24'($urandom);
            cnt[b] = 6'($urandom);
         end
         wait_busy(1'b0, 600, "frame_end");
         end_c = cyc;
         chk("frame_cnt", frame_cnt_o, tbl[i].exp_cnt);
         chk("pixels_left", exp_q.size(), 0);
         prev_start = start;
         prev_end = end_c;
         if (i < NVEC - 1) begin
            rgb = tbl[i + 1].rgb;
            cnt = tbl[i + 1].cnt;
            push_frame(tbl[i + 1].rgb, tbl[i + 1].cnt);
         end
      end

      // Reset in the middle of a frame, then a clean restart.
      mode = 0;
      rgb = basic_rgb; cnt = basic_cnt;
      push_frame(basic_rgb, basic_cnt);
      wait_busy(1'b1, 300, "rst_frame_start");
      begin
         int k;
         for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (hs_cnt >= 17) break;
         end
         chk("reach_pixel_17", (k < 200), 1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_pix", pix_o, 0);
      chk("midrst_pix_v", pix_v_o, 0);
      chk("midrst_last", last_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_frame_cnt", frame_cnt_o, 0);
      exp_q.delete();
      push_frame(basic_rgb, basic_cnt);
      rst = 1'b0;
      wait_busy(1'b1, 300, "post_rst_start");
      wait_busy(1'b0, 300, "post_rst_end");
      chk("post_rst_frame_cnt", frame_cnt_o, 1);
      chk("post_rst_pixels_left", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
